// File: rtl/keypad_pkg.sv
// ============================================================================
// keypad_pkg : shared types, constants and key-vector encoder for the keypad
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int KEY_COUNT = 10;
  localparam int BCD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  typedef struct packed {
    logic [BCD_WIDTH-1:0] code;
    logic                 onehot;
  } bcd_res_t;

  // Code is only meaningful when onehot is set.
  function automatic bcd_res_t onehot10_to_bcd(input logic [KEY_COUNT-1:0] keys);
    bcd_res_t   res;
    logic [3:0] n_set;
    res   = '0;
    n_set = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (keys[i]) begin
        res.code = BCD_WIDTH'(i);
        n_set    = n_set + 4'd1;
      end
    end
    res.onehot = (n_set == 4'd1);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : two-flop synchronizer for asynchronous level inputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/encoder_decimal_to_bcd_keypad.sv
// ============================================================================
// encoder_decimal_to_bcd_keypad : debounced 10-key keypad to BCD encoder
//                                 with a shifting multi-digit entry register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_decimal_to_bcd_keypad
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [KEY_COUNT-1:0]            key_i,
  input  logic                            clear_i,
  output logic [BCD_WIDTH-1:0]            code_o,
  output logic                            valid_o,
  output logic                            error_o,
  output logic                            busy_o,
  output logic [BCD_WIDTH*NUM_DIGITS-1:0] digits_o
);

  localparam int                DW       = BCD_WIDTH * NUM_DIGITS;
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

  logic [KEY_COUNT-1:0] ks;
  logic [KEY_COUNT-1:0] kcap_q;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_inc;
  logic [BCD_WIDTH-1:0] code_q;
  logic                 valid_q;
  logic                 error_q;
  logic                 busy_q;
  logic [DW-1:0]        digits_q;
  logic [DW-1:0]        digits_d;
  logic [DW-1:0]        digits_base;
  logic                 press_done;
  logic                 accept;
  bcd_res_t             res;

  sync_2ff #(
    .WIDTH (KEY_COUNT)
  ) u_key_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (key_i),
    .q_o    (ks)
  );

  assign res        = onehot10_to_bcd(kcap_q);
  assign cnt_inc    = cnt_q + 1'b1;
  assign press_done = (state_q == PRESS_DB) && (ks == kcap_q) && (cnt_inc == CNT_LAST);
  assign accept     = press_done && res.onehot;

  // Clear is applied first so a coincident accept lands in an all-zero register.
  always_comb begin
    digits_base = clear_i ? '0 : digits_q;
    digits_d    = digits_base;
    if (accept) begin
      digits_d = (digits_base << BCD_WIDTH) | DW'(res.code);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      kcap_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ks != '0) begin
            kcap_q  <= ks;
            cnt_q   <= '0;
            state_q <= PRESS_DB;
            busy_q  <= 1'b1;
          end
        end
        PRESS_DB: begin
          if (ks != kcap_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (press_done) begin
            cnt_q   <= cnt_inc;
            state_q <= HELD;
            if (res.onehot) begin
              code_q  <= res.code;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HELD: begin
          if (ks == '0) begin
            cnt_q   <= '0;
            state_q <= REL_DB;
          end
        end
        REL_DB: begin
          if (ks != '0) begin
            state_q <= HELD;
          end else if (cnt_inc == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign code_o   = code_q;
  assign valid_o  = valid_q;
  assign error_o  = error_q;
  assign busy_o   = busy_q;
  assign digits_o = digits_q;

endmodule

`default_nettype wire

// File: tb/tb_encoder_decimal_to_bcd_keypad.sv
// ============================================================================
// tb_encoder_decimal_to_bcd_keypad : scoreboard bench for the keypad encoder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encoder_decimal_to_bcd_keypad;

  localparam int D  = 4;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        clear_i = 1'b0;
  logic [9:0]  key_i = '0;
  logic [3:0]  code_o;
  logic        valid_o;
  logic        error_o;
  logic        busy_o;
  logic [15:0] digits_o;

  encoder_decimal_to_bcd_keypad #(
    .DEBOUNCE_CYCLES (D),
    .NUM_DIGITS      (ND)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .key_i    (key_i),
    .clear_i  (clear_i),
    .code_o   (code_o),
    .valid_o  (valid_o),
    .error_o  (error_o),
    .busy_o   (busy_o),
    .digits_o (digits_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [3:0]  code;
    logic [15:0] digits;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  m_code   = '0;
  logic [15:0] m_digits = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a press with exactly one key appends that decimal digit to the
  // entry number (four decimal places kept); any other key set is an error.
  task automatic expect_press(input logic [9:0] k, input bit clr);
    int   nset;
    int   idx;
    exp_t e;
    nset = 0;
    idx  = 0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) begin
        nset++;
        idx = i;
      end
    end
    if (nset == 1) begin
      m_code   = 4'(idx);
      m_digits = clr ? 16'(idx) : 16'((int'(m_digits) * 16 + idx) % 65536);
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.code   = m_code;
    e.digits = m_digits;
    sb.push_back(e);
  endtask

  task automatic press(input logic [9:0] k, input int bounces, input bit clr);
    for (int b = 0; b < bounces; b++) begin
      key_i = k;
      step($urandom_range(D, 1));
      key_i = '0;
      step($urandom_range(D, 1));
    end
    key_i = k;
    expect_press(k, clr);
    if (clr) begin
      step(D + 2);
      clear_i = 1'b1;
      step(1);
      clear_i = 1'b0;
    end else begin
      step(D + 3);
    end
    step(2);
    key_i = k | 10'($urandom_range(1023, 0));
    step(3);
    key_i = k;
    step(2);
    for (int b = 0; b < bounces; b++) begin
      key_i = '0;
      step($urandom_range(D, 1));
      key_i = k;
      step($urandom_range(D, 1));
    end
    key_i = '0;
    step(D + 6);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    step(1);
    clear_i  = 1'b0;
    m_digits = '0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_ni === 1'b1 && (valid_o === 1'b1 || error_o === 1'b1)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got valid=%b error=%b expected no pulse", valid_o, error_o);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, valid_o, error_o}, e.is_err ? 32'd1 : 32'd2);
        chk("code", {28'd0, code_o}, {28'd0, e.code});
        chk("digits", {16'd0, digits_o}, {16'd0, e.digits});
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] k;
    int         r;

    #2 rst_ni = 1'b0;
    step(3);
    chk("reset_values", {9'd0, code_o, valid_o, error_o, busy_o, digits_o}, 32'd0);
    rst_ni = 1'b1;
    step(2);

    // Key 7: acceptance latency and busy window.
    key_i = 10'b1 << 7;
    expect_press(key_i, 1'b0);
    step(2);
    chk("busy_before_press", {31'd0, busy_o}, 32'd0);
    step(1);
    chk("busy_in_press", {31'd0, busy_o}, 32'd1);
    step(D - 1);
    chk("valid_not_early", {31'd0, valid_o}, 32'd0);
    step(1);
    chk("valid_on_time", {31'd0, valid_o}, 32'd1);
    chk("key7_digits", {16'd0, digits_o}, 32'h0007);
    step(1);
    chk("valid_one_cycle", {31'd0, valid_o}, 32'd0);
    step(5);
    key_i = '0;
    step(D + 2);
    chk("busy_in_release", {31'd0, busy_o}, 32'd1);
    step(1);
    chk("busy_after_release", {31'd0, busy_o}, 32'd0);
    step(4);

    // Key 3 bouncing every two cycles, then held.
    for (int i = 0; i < 6; i++) begin
      key_i = (i % 2 == 0) ? (10'b1 << 3) : 10'b0;
      step(2);
    end
    press(10'b1 << 3, 0, 1'b0);
    chk("key3_code", {28'd0, code_o}, 32'd3);

    // Keys 2 and 5 together.
    press((10'b1 << 2) | (10'b1 << 5), 0, 1'b0);
    chk("multi_key_code_kept", {28'd0, code_o}, 32'd3);
    chk("multi_key_digits_kept", {16'd0, digits_o}, 32'h0073);

    pulse_clear();
    chk("clear_idle", {16'd0, digits_o}, 32'h0000);

    press(10'b1 << 1, 0, 1'b0);
    press(10'b1 << 9, 1, 1'b0);
    press(10'b1 << 8, 0, 1'b0);
    press(10'b1 << 4, 2, 1'b0);
    chk("seq_1984", {16'd0, digits_o}, 32'h1984);
    press(10'b1 << 0, 0, 1'b0);
    chk("seq_9840", {16'd0, digits_o}, 32'h9840);

    press(10'b1 << 6, 0, 1'b1);
    chk("clear_with_accept", {16'd0, digits_o}, 32'h0006);

    // Reset during press debounce with the key held through it.
    key_i = 10'b1 << 5;
    step(4);
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_async", {9'd0, code_o, valid_o, error_o, busy_o, digits_o}, 32'd0);
    m_code   = '0;
    m_digits = '0;
    step(2);
    rst_ni = 1'b1;
    expect_press(key_i, 1'b0);
    step(D + 2);
    chk("rerelease_not_early", {31'd0, valid_o}, 32'd0);
    step(1);
    chk("rerelease_on_time", {31'd0, valid_o}, 32'd1);
    step(3);
    key_i = '0;
    step(D + 6);

    // Randomized presses.
    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(9, 0));
      if ($urandom_range(4, 0) == 0) begin
        k = (10'b1 << r) | (10'b1 << ((r + 1 + int'($urandom_range(8, 0))) % 10));
      end else begin
        k = 10'b1 << r;
      end
      press(k, int'($urandom_range(3, 0)), 1'b0);
      if ($urandom_range(3, 0) == 0) begin
        pulse_clear();
      end
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    chk("queue_drained", sb.size(), 32'd0);
    chk("final_digits", {16'd0, digits_o}, {16'd0, m_digits});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
